// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one shift-add stage reused ITER times per request.
// Rotation gives cos/sin over the full circle; vectoring gives magnitude/atan2.
module cordic_iter_engine #(
   parameter int DATA_WIDTH = 16,
   parameter int ITER       = 14,
   parameter int GUARD      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [DATA_WIDTH-1:0] in_x,
   input  logic [DATA_WIDTH-1:0] in_y,
   input  logic [DATA_WIDTH-1:0] in_z,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_x,
   output logic [DATA_WIDTH-1:0] out_y,
   output logic [DATA_WIDTH-1:0] out_z,
   output logic                  out_ovf
);
   localparam int W  = DATA_WIDTH;
   localparam int ZW = W + GUARD;
   // Two growth bits: a full-scale diagonal vector grows by sqrt(2)*K ~ 2.33 before Kinv.
   localparam int IW = W + GUARD + 2;
   localparam int FX = W - 2 + GUARD;
   localparam int KW = ZW + 1;
   localparam int PW = IW + KW;
   localparam int SH = GUARD + ZW;
   localparam int CW = 5;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_POST, S_DONE} state_e;

   // 1/K = 1/sqrt(prod(1 + 4^-i)), evaluated in wide fixed point at elaboration.
   function automatic logic [ZW-1:0] kinv_calc();
      logic [127:0] p;
      logic [127:0] num;
      logic [63:0]  root;
      logic [63:0]  trial;
      p = 128'd1 << 60;
      for (int i = 0; i < ITER; i++) p = p + (p >> (2 * i));
      root = '0;
      for (int b = 63; b >= 0; b--) begin
         trial = root | (64'd1 << b);
         if ({64'd0, trial} * {64'd0, trial} <= (p << 60)) root = trial;
      end
      num = (128'd1 << (ZW + 60)) + {65'd0, root[63:1]};
      return ZW'(num / {64'd0, root});
   endfunction

   function automatic logic [ZW-1:0] atan_rnd(input logic [CW-1:0] idx);
      logic [31:0] c;
      case (idx)
         5'd0:  c = 32'h20000000;
         5'd1:  c = 32'h12E4051E;
         5'd2:  c = 32'h09FB385B;
         5'd3:  c = 32'h051111D4;
         5'd4:  c = 32'h028B0D43;
         5'd5:  c = 32'h0145D7E1;
         5'd6:  c = 32'h00A2F61E;
         5'd7:  c = 32'h00517C55;
         5'd8:  c = 32'h0028BE53;
         5'd9:  c = 32'h00145F2F;
         5'd10: c = 32'h000A2F98;
         5'd11: c = 32'h000517CC;
         5'd12: c = 32'h00028BE6;
         5'd13: c = 32'h000145F3;
         5'd14: c = 32'h0000A2FA;
         5'd15: c = 32'h0000517D;
         5'd16: c = 32'h000028BE;
         5'd17: c = 32'h0000145F;
         5'd18: c = 32'h00000A30;
         5'd19: c = 32'h00000518;
         5'd20: c = 32'h0000028C;
         5'd21: c = 32'h00000146;
         5'd22: c = 32'h000000A3;
         5'd23: c = 32'h00000051;
         default: c = 32'h0;
      endcase
      c = c + (32'd1 << (31 - ZW));
      return ZW'(c >> (32 - ZW));
   endfunction

   localparam logic signed [KW-1:0] KINV    = {1'b0, kinv_calc()};
   localparam logic signed [IW-1:0] ONE     = {{(IW-FX-1){1'b0}}, 1'b1, {FX{1'b0}}};
   localparam logic signed [IW-1:0] IN_MIN  = {3'b111, {(W+GUARD-1){1'b0}}};
   localparam logic signed [IW-1:0] IN_MAX  = {3'b000, {(W-1){1'b1}}, {GUARD{1'b0}}};
   localparam logic signed [PW-1:0] HALF    = {{(PW-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
   localparam logic signed [PW-1:0] SAT_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [ZW-1:0]        Z_HALF  = {{(ZW-GUARD){1'b0}}, 1'b1, {(GUARD-1){1'b0}}};

   function automatic logic signed [IW-1:0] neg_sat(input logic signed [IW-1:0] v);
      return (v == IN_MIN) ? IN_MAX : -v;
   endfunction

   // Returns {clipped, value}.
   function automatic logic [W:0] sat_w(input logic signed [PW-1:0] v);
      if (v > SAT_MAX)      return {1'b1, SAT_MAX[W-1:0]};
      else if (v < SAT_MIN) return {1'b1, SAT_MIN[W-1:0]};
      else                  return {1'b0, v[W-1:0]};
   endfunction

   state_e                 state_q, state_d;
   logic                   mode_q, mode_d, neg_q, neg_d;
   logic [CW-1:0]          i_q, i_d;
   logic signed [IW-1:0]   x_q, x_d, y_q, y_d;
   logic [ZW-1:0]          z_q, z_d;
   logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [W-1:0]           out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
   logic                   out_ovf_q, out_ovf_d;
   logic                   rot_pos;
   logic signed [IW-1:0]   xs, ys;
   logic [ZW-1:0]          at, z_fin;
   logic signed [PW-1:0]   prod_x, prod_y;
   logic [W:0]             sx, sy;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves a latch behind.
      state_d     = state_q;
      mode_d      = mode_q;
      neg_d       = neg_q;
      i_d         = i_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_z_d     = out_z_q;
      out_ovf_d   = out_ovf_q;

      rot_pos = mode_q ? y_q[IW-1] : ~z_q[ZW-1];
      xs      = x_q >>> i_q;
      ys      = y_q >>> i_q;
      at      = atan_rnd(i_q);
      prod_x  = x_q * KINV;
      prod_y  = y_q * KINV;
      if (!mode_q && neg_q) begin
         prod_x = -prod_x;
         prod_y = -prod_y;
      end
      sx    = sat_w((prod_x + HALF) >>> SH);
      sy    = sat_w((prod_y + HALF) >>> SH);
      z_fin = (mode_q && neg_q) ? {~z_q[ZW-1], z_q[ZW-2:0]} : z_q;

      case (state_q)
         S_IDLE: if (in_valid) begin
            mode_d     = in_mode;
            x_d        = {{2{in_x[W-1]}}, in_x, {GUARD{1'b0}}};
            y_d        = {{2{in_y[W-1]}}, in_y, {GUARD{1'b0}}};
            z_d        = {in_z, {GUARD{1'b0}}};
            in_ready_d = 1'b0;
            state_d    = S_PRE;
         end
         S_PRE: begin
            i_d     = '0;
            neg_d   = 1'b0;
            state_d = S_ITER;
            if (!mode_q) begin
               x_d = ONE;
               y_d = '0;
               // |angle| >= pi/2: shift by pi into the convergent range, undo by negation later.
               if (z_q[ZW-1] ^ z_q[ZW-2]) begin
                  z_d   = {~z_q[ZW-1], z_q[ZW-2:0]};
                  neg_d = 1'b1;
               end
            end else begin
               z_d = '0;
               if (x_q[IW-1]) begin
                  x_d   = neg_sat(x_q);
                  y_d   = neg_sat(y_q);
                  neg_d = 1'b1;
               end
            end
         end
         S_ITER: begin
            if (rot_pos) begin
               x_d = x_q - ys;
               y_d = y_q + xs;
               z_d = z_q - at;
            end else begin
               x_d = x_q + ys;
               y_d = y_q - xs;
               z_d = z_q + at;
            end
            if (i_q == CW'(ITER - 1)) state_d = S_POST;
            else                      i_d     = i_q + 1'b1;
         end
         S_POST: begin
            out_x_d     = sx[W-1:0];
            out_y_d     = sy[W-1:0];
            out_ovf_d   = sx[W] | sy[W];
            out_z_d     = W'((z_fin + Z_HALF) >> GUARD);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: if (out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         neg_q       <= 1'b0;
         i_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_z_q     <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         neg_q       <= neg_d;
         i_q         <= i_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_z_q     <= out_z_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign out_z     = out_z_q;
   assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine (W=16, ITER=14, GUARD=4) with hand-computed
// expectations: Q2.14 gives 1.0 = 16384, binary angle gives pi = 0x8000.
module tb_cordic_iter_engine;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_mode, out_valid, out_ready, out_ovf;
   logic [W-1:0] in_x, in_y, in_z, out_x, out_y, out_z;

   int n_checks = 0;
   int n_errors = 0;

   logic signed [W-1:0] got_x, got_y;
   logic [W-1:0]        got_z;
   logic                got_ovf;
   int                  got_lat;

   cordic_iter_engine #(.DATA_WIDTH(16), .ITER(14), .GUARD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_z      (in_z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_z     (out_z),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // ang=1 compares modulo 2^16, for binary-angle outputs.
   task automatic check(input string tag, input int obs, input int exp, input int tol, input bit ang);
      int diff;
      logic signed [15:0] d16;
      n_checks++;
      diff = obs - exp;
      if (ang) begin
         d16  = 16'(diff);
         diff = int'(d16);
      end
      if (diff > tol || diff < -tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d +/- %0d", tag, obs, exp, tol);
      end
   endtask

   task automatic run_txn(input logic mode, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z);
      int wait_cyc;
      wait_cyc = 0;
      in_mode  = mode;
      in_x     = x;
      in_y     = y;
      in_z     = z;
      in_valid = 1'b1;
      while (!in_ready && wait_cyc < 50) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      check("accept_ready", int'(in_ready), 1, 0, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_mode  = ~mode;
      got_lat  = 0;
      while (!out_valid && got_lat < 100) begin
         @(posedge clk); #1;
         got_lat++;
      end
      check("latency", got_lat, 16, 0, 1'b0);
      got_x   = out_x;
      got_y   = out_y;
      got_z   = out_z;
      got_ovf = out_ovf;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hs_out_valid", int'(out_valid), 0, 0, 1'b0);
      check("hs_in_ready", int'(in_ready), 1, 0, 1'b0);
   endtask

   task automatic quiet_window(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check(tag, seen, 0, 0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_z      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", int'(in_ready), 1, 0, 1'b0);
      check("rst_out_valid", int'(out_valid), 0, 0, 1'b0);
      check("rst_out_x", int'(out_x), 0, 0, 1'b0);
      check("rst_out_y", int'(out_y), 0, 0, 1'b0);
      check("rst_out_z", int'(out_z), 0, 0, 1'b0);
      check("rst_out_ovf", int'(out_ovf), 0, 0, 1'b0);

      // Rotation: 0, +pi/2 (fold), -pi (fold), -pi/2 (no fold).
      run_txn(1'b0, 16'h0000, 16'h0000, 16'h0000);
      check("rot0_x", int'(got_x), 16384, 3, 1'b0);
      check("rot0_y", int'(got_y), 0, 3, 1'b0);
      check("rot0_z", int'(got_z), 0, 3, 1'b1);
      check("rot0_ovf", int'(got_ovf), 0, 0, 1'b0);
      consume();
      run_txn(1'b0, 16'h1234, 16'h4321, 16'h4000);
      check("rot90_x", int'(got_x), 0, 3, 1'b0);
      check("rot90_y", int'(got_y), 16384, 3, 1'b0);
      consume();
      run_txn(1'b0, 16'h0000, 16'h0000, 16'h8000);
      check("rotm180_x", int'(got_x), -16384, 3, 1'b0);
      check("rotm180_y", int'(got_y), 0, 3, 1'b0);
      consume();
      run_txn(1'b0, 16'h0000, 16'h0000, 16'hC000);
      check("rotm90_x", int'(got_x), 0, 3, 1'b0);
      check("rotm90_y", int'(got_y), -16384, 3, 1'b0);
      consume();

      // Vectoring: (0.6, 0.8), (-1, 0) through the x<0 fold.
      run_txn(1'b1, 16'd9830, 16'd13107, 16'h0000);
      check("vec68_x", int'(got_x), 16384, 3, 1'b0);
      check("vec68_y", int'(got_y), 0, 3, 1'b0);
      check("vec68_z", int'(got_z), 9672, 3, 1'b1);
      check("vec68_ovf", int'(got_ovf), 0, 0, 1'b0);
      consume();
      run_txn(1'b1, 16'hC000, 16'h0000, 16'h0000);
      check("vecneg_x", int'(got_x), 16384, 3, 1'b0);
      check("vecneg_z", int'(got_z), 32768, 3, 1'b1);
      consume();

      // Backpressure on a pi/4 rotation: held for 10 cycles while in_valid pulses.
      run_txn(1'b0, 16'h0000, 16'h0000, 16'h2000);
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         in_mode  = k[1];
         in_z     = 16'($urandom_range(0, 65535));
         @(posedge clk); #1;
         check("bp_valid", int'(out_valid), 1, 0, 1'b0);
         check("bp_in_ready", int'(in_ready), 0, 0, 1'b0);
         check("bp_x", int'($signed(out_x)), 11585, 3, 1'b0);
         check("bp_y", int'($signed(out_y)), 11585, 3, 1'b0);
         check("bp_z", int'(out_z), 0, 3, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_hs_valid", int'(out_valid), 0, 0, 1'b0);
      check("bp_hs_ready", int'(in_ready), 1, 0, 1'b0);
      // out_ready stays high in IDLE: nothing may happen.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("idle_rdy_valid", int'(out_valid), 0, 0, 1'b0);
         check("idle_rdy_ready", int'(in_ready), 1, 0, 1'b0);
      end
      out_ready = 1'b0;
      quiet_window("bp_no_queue", 20);

      // Full-scale diagonal: magnitude clips.
      run_txn(1'b1, 16'h7FFF, 16'h7FFF, 16'h0000);
      check("sat_x", int'(got_x), 32767, 0, 1'b0);
      check("sat_ovf", int'(got_ovf), 1, 0, 1'b0);
      check("sat_z", int'(got_z), 8192, 3, 1'b1);
      consume();

      // Reset during ITER: previously held saturated outputs must clear at once.
      in_mode  = 1'b0;
      in_z     = 16'h4000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_valid", int'(out_valid), 0, 0, 1'b0);
      check("mid_rst_x", int'(out_x), 0, 0, 1'b0);
      check("mid_rst_y", int'(out_y), 0, 0, 1'b0);
      check("mid_rst_z", int'(out_z), 0, 0, 1'b0);
      check("mid_rst_ovf", int'(out_ovf), 0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      quiet_window("mid_rst_discard", 20);
      run_txn(1'b0, 16'h0000, 16'h0000, 16'h0000);
      check("after_rst_x", int'(got_x), 16384, 3, 1'b0);
      check("after_rst_y", int'(got_y), 0, 3, 1'b0);
      consume();
      quiet_window("after_rst_single", 20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
